// File: rtl/pll_lock_supervisor_if.sv
// Connection bundle between the PLL lock supervisor, the PLL and the downstream reset consumers.
// The supervisor connects through master; a PLL model or bench connects through slave.
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             locked_in;
    logic             clear;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic             fail;
    logic [2:0]       state;
    logic [3:0]       retry_count;
    logic [CNT_W-1:0] loss_count;

    modport master (
        input  locked_in, clear,
        output pll_rst, sys_rst, ready, fail, state, retry_count, loss_count
    );

    modport slave (
        output locked_in, clear,
        input  pll_rst, sys_rst, ready, fail, state, retry_count, loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences the system PLL reset, qualifies its lock, and issues the system reset and ready flag.
// Lock timeouts are retried a bounded number of times; lock losses while running are counted.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 8,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_lock_supervisor_if.master bus
);

    localparam int T_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int T_MAX   = (T_MAX_A > RST_CYCLES) ? T_MAX_A : RST_CYCLES;
    localparam int TW      = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    state_t           state_r, next_state_s;
    logic [TW-1:0]    timer_r, timer_nxt_s;
    logic [3:0]       retry_r, retry_nxt_s, retry_inc_s;
    logic [CNT_W-1:0] loss_r, loss_nxt_s;
    logic             sync_meta_r, locked_s;
    logic             pll_rst_r, sys_rst_r, ready_r, fail_r;
    logic             pll_rst_d_s, sys_rst_d_s, ready_d_s, fail_d_s;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            sync_meta_r <= bus.locked_in;
            locked_s    <= sync_meta_r;
        end
    end

    // State, shared timer and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_RESET_PLL;
            timer_r <= '0;
            retry_r <= 4'd0;
            loss_r  <= '0;
        end else begin
            state_r <= next_state_s;
            timer_r <= timer_nxt_s;
            retry_r <= retry_nxt_s;
            loss_r  <= loss_nxt_s;
        end
    end

    assign retry_inc_s = retry_r + 4'd1;

    // Next-state, timer and counter update; the timer restarts on every state entry.
    always_comb begin
        next_state_s = state_r;
        timer_nxt_s  = timer_r + TW'(1);
        retry_nxt_s  = retry_r;
        loss_nxt_s   = loss_r;
        case (state_r)
            S_RESET_PLL: begin
                if (timer_r == TW'(RST_CYCLES - 1)) begin
                    next_state_s = S_WAIT_LOCK;
                    timer_nxt_s  = '0;
                end else begin
                    next_state_s = S_RESET_PLL;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    next_state_s = S_STABLE;
                    timer_nxt_s  = '0;
                end else if (timer_r == TW'(LOCK_TIMEOUT - 1)) begin
                    timer_nxt_s = '0;
                    retry_nxt_s = retry_inc_s;
                    if (retry_inc_s == 4'(MAX_RETRIES)) begin
                        next_state_s = S_FAIL;
                    end else begin
                        next_state_s = S_RESET_PLL;
                    end
                end else begin
                    next_state_s = S_WAIT_LOCK;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    next_state_s = S_WAIT_LOCK;
                    timer_nxt_s  = '0;
                end else if (timer_r == TW'(STABLE_CYCLES - 1)) begin
                    next_state_s = S_RUN;
                    timer_nxt_s  = '0;
                    retry_nxt_s  = 4'd0;
                end else begin
                    next_state_s = S_STABLE;
                end
            end
            S_RUN: begin
                timer_nxt_s = '0;
                if (!locked_s) begin
                    next_state_s = S_RESET_PLL;
                    loss_nxt_s   = sat_inc(loss_r);
                end else begin
                    next_state_s = S_RUN;
                end
            end
            S_FAIL: begin
                timer_nxt_s = '0;
                if (bus.clear) begin
                    next_state_s = S_RESET_PLL;
                    retry_nxt_s  = 4'd0;
                end else begin
                    next_state_s = S_FAIL;
                end
            end
            default: begin
                next_state_s = S_RESET_PLL;
                timer_nxt_s  = '0;
            end
        endcase
        // clear takes priority over a same-cycle loss increment
        if (bus.clear) begin
            loss_nxt_s = '0;
        end else begin
            loss_nxt_s = loss_nxt_s;
        end
    end

    // Output decode from the next state so the registered outputs line up with state.
    always_comb begin
        pll_rst_d_s = 1'b1;
        sys_rst_d_s = 1'b1;
        ready_d_s   = 1'b0;
        fail_d_s    = 1'b0;
        case (next_state_s)
            S_RESET_PLL: begin
                pll_rst_d_s = 1'b1;
            end
            S_WAIT_LOCK, S_STABLE: begin
                pll_rst_d_s = 1'b0;
            end
            S_RUN: begin
                pll_rst_d_s = 1'b0;
                sys_rst_d_s = 1'b0;
                ready_d_s   = 1'b1;
            end
            S_FAIL: begin
                fail_d_s = 1'b1;
            end
            default: begin
                pll_rst_d_s = 1'b1;
            end
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_rst_r <= 1'b1;
            sys_rst_r <= 1'b1;
            ready_r   <= 1'b0;
            fail_r    <= 1'b0;
        end else begin
            pll_rst_r <= pll_rst_d_s;
            sys_rst_r <= sys_rst_d_s;
            ready_r   <= ready_d_s;
            fail_r    <= fail_d_s;
        end
    end

    assign bus.pll_rst     = pll_rst_r;
    assign bus.sys_rst     = sys_rst_r;
    assign bus.ready       = ready_r;
    assign bus.fail        = fail_r;
    assign bus.state       = state_r;
    assign bus.retry_count = retry_r;
    assign bus.loss_count  = loss_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pll_lock_supervisor;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n;
    int   cnt;

    pll_lock_supervisor_if #(.CNT_W(4)) bus ();

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .CNT_W         (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Counts falling edges until state reaches s; gives up after budget edges.
    task automatic wait_state(input logic [2:0] s, input int budget, output int waited);
        waited = 0;
        while (bus.state !== s && waited < budget) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic relock();
        int w;
        wait_state(3'd1, 20, w);
        bus.locked_in = 1'b1;
        wait_state(3'd3, 40, w);
        chk("relock_run", bus.state, 3);
    endtask

    // Lock drop: two synchronizer edges, then the FSM edge, so state moves on the third sample.
    task automatic lose(input int exp_loss);
        int w;
        bus.locked_in = 1'b0;
        wait_state(3'd0, 10, w);
        chk("loss_latency", w, 3);
        chk("loss_count", bus.loss_count, exp_loss);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.locked_in = 1'b0;
        bus.clear     = 1'b0;
        tick(3);

        chk("rst_state", bus.state, 0);
        chk("rst_pll_rst", bus.pll_rst, 1);
        chk("rst_sys_rst", bus.sys_rst, 1);
        chk("rst_ready", bus.ready, 0);
        chk("rst_fail", bus.fail, 0);
        chk("rst_retry", bus.retry_count, 0);
        chk("rst_loss", bus.loss_count, 0);

        // Normal lock-up
        rst = 1'b0;
        cnt = 0;
        while (bus.pll_rst === 1'b1 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("pll_rst_len", cnt, 4);
        chk("wait_lock_state", bus.state, 1);
        chk("wait_sys_rst", bus.sys_rst, 1);
        tick(2);
        bus.locked_in = 1'b1;
        wait_state(3'd2, 10, n);
        chk("stable_entry", n, 3);
        wait_state(3'd3, 20, n);
        chk("stable_len", n, 8);
        chk("run_ready", bus.ready, 1);
        chk("run_sys_rst", bus.sys_rst, 0);
        chk("run_pll_rst", bus.pll_rst, 0);
        chk("run_retry", bus.retry_count, 0);

        // Loss in RUN, repeated until the counter saturates
        lose(1);
        chk("loss_sys_rst", bus.sys_rst, 1);
        chk("loss_ready", bus.ready, 0);
        chk("loss_pll_rst", bus.pll_rst, 1);
        for (int i = 2; i <= 16; i++) begin
            relock();
            lose((i < 15) ? i : 15);
        end

        // Async reset mid-RUN with a saturated loss counter
        relock();
        rst = 1'b1;
        #1;
        chk("arst_run_state", bus.state, 0);
        chk("arst_run_pll_rst", bus.pll_rst, 1);
        chk("arst_run_sys_rst", bus.sys_rst, 1);
        chk("arst_run_ready", bus.ready, 0);
        chk("arst_run_loss", bus.loss_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // clear in the same cycle the FSM sees the lock drop
        wait_state(3'd3, 40, n);
        chk("coll_run", bus.state, 3);
        bus.locked_in = 1'b0;
        tick(2);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        chk("coll_state", bus.state, 0);
        chk("coll_loss", bus.loss_count, 0);

        // clear in WAIT_LOCK with loss_count=5
        for (int i = 1; i <= 5; i++) begin
            relock();
            lose(i);
        end
        wait_state(3'd1, 10, n);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        chk("clr_wait_loss", bus.loss_count, 0);
        chk("clr_wait_state", bus.state, 1);

        // Unstable lock: drop for 3 cycles at STABLE cycle 5
        bus.locked_in = 1'b1;
        wait_state(3'd2, 10, n);
        chk("unst_entry", n, 3);
        tick(4);
        chk("unst_mid", bus.state, 2);
        bus.locked_in = 1'b0;
        wait_state(3'd1, 10, n);
        chk("unst_back_wait", n, 3);
        bus.locked_in = 1'b1;
        wait_state(3'd2, 10, n);
        chk("unst_reentry", n, 3);
        wait_state(3'd3, 20, n);
        chk("unst_fresh_len", n, 8);
        chk("unst_retry", bus.retry_count, 0);

        // Timeout and FAIL
        bus.locked_in = 1'b0;
        wait_state(3'd0, 10, n);
        chk("to_loss", bus.loss_count, 1);
        for (int i = 1; i <= 3; i++) begin
            wait_state(3'd1, 10, n);
            chk("to_reset_len", n, 4);
            if (i < 3) begin
                wait_state(3'd0, 30, n);
                chk("to_wait_len", n, 20);
                chk("to_retry", bus.retry_count, i);
            end else begin
                wait_state(3'd4, 30, n);
                chk("to_fail_len", n, 20);
            end
        end
        chk("fail_state", bus.state, 4);
        chk("fail_flag", bus.fail, 1);
        chk("fail_retry", bus.retry_count, 3);
        chk("fail_pll_rst", bus.pll_rst, 1);
        chk("fail_sys_rst", bus.sys_rst, 1);
        chk("fail_ready", bus.ready, 0);
        bus.locked_in = 1'b1;
        tick(10);
        chk("fail_ignore_lock", bus.state, 4);
        chk("fail_hold_flag", bus.fail, 1);
        bus.locked_in = 1'b0;
        tick(3);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        chk("fail_clr_state", bus.state, 0);
        chk("fail_clr_flag", bus.fail, 0);
        chk("fail_clr_retry", bus.retry_count, 0);
        chk("fail_clr_pll_rst", bus.pll_rst, 1);

        // Async reset mid-STABLE with one retry recorded
        wait_state(3'd1, 10, n);
        wait_state(3'd0, 30, n);
        chk("retry_one", bus.retry_count, 1);
        wait_state(3'd1, 10, n);
        bus.locked_in = 1'b1;
        wait_state(3'd2, 10, n);
        tick(3);
        chk("arst_stb_pre", bus.state, 2);
        rst = 1'b1;
        #1;
        chk("arst_stb_state", bus.state, 0);
        chk("arst_stb_retry", bus.retry_count, 0);
        chk("arst_stb_pll_rst", bus.pll_rst, 1);
        chk("arst_stb_sys_rst", bus.sys_rst, 1);
        chk("arst_stb_ready", bus.ready, 0);
        chk("arst_stb_fail", bus.fail, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
